ifu_fetch_buf: RTL and testbench



---
 rtl/ifu_fetch_buf.sv | 103 ++++++++++
 tb/tb_ifu_fetch_buf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buf.sv
// Fetch-line buffer between the ICache and decode: queues 128-bit lines with their PCs
// and presents up to two in-line instructions per cycle, with branch predecode.
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif

module ifu_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int SKID  = 2,
  parameter int PC_W  = `CORE_PC_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_icache_line_vld,
  input  logic [127:0]    i_icache_line,
  input  logic [PC_W-1:0] i_line_pc,
  output logic            o_ibuf_icache_stall,
  input  logic            i_dec_rdy,
  output logic [1:0]      o_ibuf_vld,
  output logic [31:0]     o_ibuf_instr0,
  output logic [31:0]     o_ibuf_instr1,
  output logic [PC_W-1:0] o_ibuf_pc0,
  output logic [PC_W-1:0] o_ibuf_pc1,
  output logic [1:0]      o_ibuf_is_br,
  output logic            o_ibuf_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);

  logic [127:0]    line_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   cnt, free_cnt;
  logic [1:0]    head_slot, slot1;
  logic [2:0]    slot_sum;
  logic          nonempty, two_vld, write_en, consume, retire;
  logic [127:0]  head_line;

  function automatic logic is_branch(input logic [31:0] w);
    return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
  endfunction

  assign nonempty   = (cnt != '0);
  assign two_vld    = nonempty && (head_slot != 2'd3);
  assign slot1      = head_slot + 2'd1;
  assign head_line  = line_mem[rd_ptr];
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  assign o_ibuf_vld    = {two_vld, nonempty};
  assign o_ibuf_empty  = ~nonempty;
  assign o_ibuf_instr0 = head_line[{head_slot, 5'd0} +: 32];
  assign o_ibuf_instr1 = head_line[{slot1, 5'd0} +: 32];
  assign o_ibuf_pc0    = {pc_mem[rd_ptr][PC_W-1:4], head_slot, 2'b00};
  assign o_ibuf_pc1    = {pc_mem[rd_ptr][PC_W-1:4], slot1, 2'b00};
  assign o_ibuf_is_br  = {two_vld & is_branch(o_ibuf_instr1), nonempty & is_branch(o_ibuf_instr0)};

  assign free_cnt            = DEPTH_V - cnt;
  assign o_ibuf_icache_stall = 32'(free_cnt) <= 32'(SKID);

  assign write_en = i_icache_line_vld & ~i_flush & (cnt != DEPTH_V);
  assign consume  = i_dec_rdy & nonempty;
  // Carry out of the 2-bit slot index means the head line is exhausted.
  assign slot_sum = {1'b0, head_slot} + (two_vld ? 3'd2 : 3'd1);
  assign retire   = consume & slot_sum[2];

  always_ff @(posedge clk) begin
    if (write_en) begin
      line_mem[wr_ptr] <= i_icache_line;
      pc_mem[wr_ptr]   <= i_line_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      head_slot <= 2'd0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + AW'(1);
      if (retire)   rd_ptr <= rd_ptr_nxt;
      case ({write_en, retire})
        2'b10:   cnt <= cnt + ONE_V;
        2'b01:   cnt <= cnt - ONE_V;
        default: cnt <= cnt;
      endcase
      // With one entry left, the next head can only be the line arriving this cycle.
      if (retire) begin
        if (cnt == ONE_V) head_slot <= write_en ? i_line_pc[3:2] : 2'd0;
        else              head_slot <= pc_mem[rd_ptr_nxt][3:2];
      end else if (consume) begin
        head_slot <= slot_sum[1:0];
      end else if (write_en && !nonempty) begin
        head_slot <= i_line_pc[3:2];
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Testbench for ifu_fetch_buf: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-of-lines reference model.
module tb_ifu_fetch_buf;

  localparam int DEPTH = 4;
  localparam int SKID  = 2;
  localparam int PC_W  = 32;
  localparam logic [127:0] LINE_A = 128'h44443333_22221111_DDCCBBAA_00000063;

  logic         clk = 1'b0;
  logic         rst, flush, line_vld, dec_rdy;
  logic [127:0] line;
  logic [31:0]  line_pc;
  logic         stall, empty;
  logic [1:0]   vld, is_br;
  logic [31:0]  instr0, instr1, pc0, pc1;

  int n_cmp = 0;
  int n_err = 0;

  ifu_fetch_buf #(.DEPTH(DEPTH), .SKID(SKID), .PC_W(PC_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_flush             (flush),
    .i_icache_line_vld   (line_vld),
    .i_icache_line       (line),
    .i_line_pc           (line_pc),
    .o_ibuf_icache_stall (stall),
    .i_dec_rdy           (dec_rdy),
    .o_ibuf_vld          (vld),
    .o_ibuf_instr0       (instr0),
    .o_ibuf_instr1       (instr1),
    .o_ibuf_pc0          (pc0),
    .o_ibuf_pc1          (pc1),
    .o_ibuf_is_br        (is_br),
    .o_ibuf_empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] line;
    logic [31:0]  pc;
  } entry_t;

  entry_t mq[$];
  int     mslot = 0;
  bit     armed = 1'b0;

  function automatic bit isBr(input logic [31:0] w);
    return (w[6:0] == 7'h63) || (w[6:0] == 7'h6f) || (w[6:0] == 7'h67);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r_rst, input logic r_flush, input logic r_vld,
                               input logic [127:0] r_line, input logic [31:0] r_pc,
                               input logic r_rdy);
    rst      = r_rst;
    flush    = r_flush;
    line_vld = r_vld;
    line     = r_line;
    line_pc  = r_pc;
    dec_rdy  = r_rdy;
    @(negedge clk);
  endtask

  // Reference model: a queue of whole lines plus the index of the next unconsumed slot.
  always @(posedge clk) begin : model
    int old_size, adv;
    bit cons, ret, wr;
    if (rst || flush) begin
      mq.delete();
      mslot = 0;
      if (rst) armed = 1'b1;
    end else begin
      old_size = mq.size();
      cons     = dec_rdy && (old_size > 0);
      adv      = (mslot == 3) ? 1 : 2;
      ret      = cons && (mslot + adv >= 4);
      wr       = line_vld && (old_size < DEPTH);
      if (line_vld && !wr) $display("[TB] note: write at full occupancy dropped (protocol violation)");
      if (ret) void'(mq.pop_front());
      if (wr) mq.push_back('{line, line_pc});
      if (ret)                      mslot = (mq.size() > 0) ? int'(mq[0].pc[3:2]) : 0;
      else if (cons)                mslot = mslot + adv;
      else if (wr && old_size == 0) mslot = int'(line_pc[3:2]);
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0]  ev;
    logic [31:0] w0, w1;
    logic [1:0]  s0, s1;
    if (armed) begin
      ev[0] = mq.size() > 0;
      ev[1] = ev[0] && (mslot != 3);
      checkOutput("empty", 64'(empty), 64'(mq.size() == 0));
      checkOutput("stall", 64'(stall), 64'((DEPTH - mq.size()) <= SKID));
      checkOutput("vld", 64'(vld), 64'(ev));
      if (ev[0]) begin
        s0 = mslot[1:0];
        s1 = s0 + 2'd1;
        w0 = mq[0].line[mslot*32 +: 32];
        checkOutput("instr0", 64'(instr0), 64'(w0));
        checkOutput("pc0", 64'(pc0), 64'({mq[0].pc[31:4], s0, 2'b00}));
        checkOutput("is_br0", 64'(is_br[0]), 64'(isBr(w0)));
        if (ev[1]) begin
          w1 = mq[0].line[(mslot+1)*32 +: 32];
          checkOutput("instr1", 64'(instr1), 64'(w1));
          checkOutput("pc1", 64'(pc1), 64'({mq[0].pc[31:4], s1, 2'b00}));
          checkOutput("is_br1", 64'(is_br[1]), 64'(isBr(w1)));
        end
      end
    end
  end

  function automatic logic [127:0] randLine();
    logic [127:0] l;
    logic [31:0]  w;
    logic [6:0]   ops [4];
    ops = '{7'h63, 7'h6f, 7'h67, 7'h13};
    for (int k = 0; k < 4; k++) begin
      w = $urandom();
      if ($urandom_range(0, 1) == 1) w[6:0] = ops[$urandom_range(0, 3)];
      l[k*32 +: 32] = w;
    end
    return l;
  endfunction

  initial begin
    logic r_rst, r_flush, r_vld;
    applyStimulus(1, 0, 0, '0, '0, 0);
    checkOutput("reset_vld", 64'(vld), 64'(0));
    checkOutput("reset_empty", 64'(empty), 64'(1));
    checkOutput("reset_stall", 64'(stall), 64'(0));

    // Aligned line drains two slots per cycle
    applyStimulus(0, 0, 1, LINE_A, 32'h1000, 1);
    checkOutput("a_vld", 64'(vld), 64'(2'b11));
    checkOutput("a_pc0", 64'(pc0), 64'(32'h1000));
    checkOutput("a_pc1", 64'(pc1), 64'(32'h1004));
    checkOutput("a_instr0", 64'(instr0), 64'(32'h00000063));
    checkOutput("a_is_br", 64'(is_br), 64'(2'b01));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("a_pc0b", 64'(pc0), 64'(32'h1008));
    checkOutput("a_pc1b", 64'(pc1), 64'(32'h100C));
    checkOutput("a_instr0b", 64'(instr0), 64'(32'h22221111));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("a_vld_end", 64'(vld), 64'(0));
    checkOutput("a_empty_end", 64'(empty), 64'(1));

    applyStimulus(0, 0, 1, LINE_A, 32'h200C, 1);
    checkOutput("u_vld", 64'(vld), 64'(2'b01));
    checkOutput("u_pc0", 64'(pc0), 64'(32'h200C));
    checkOutput("u_instr0", 64'(instr0), 64'(32'h44443333));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("u_empty", 64'(empty), 64'(1));

    applyStimulus(0, 0, 1, randLine(), 32'h300C, 0);
    checkOutput("f_stall1", 64'(stall), 64'(0));
    applyStimulus(0, 0, 1, randLine(), 32'h400C, 0);
    checkOutput("f_stall2", 64'(stall), 64'(1));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("f_stall_drop", 64'(stall), 64'(0));
    checkOutput("f_pc0", 64'(pc0), 64'(32'h400C));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("f_empty", 64'(empty), 64'(1));

    // Write+retire at three entries, then wrap into entry 0
    applyStimulus(0, 0, 1, randLine(), 32'h600C, 0);
    applyStimulus(0, 0, 1, randLine(), 32'h7000, 0);
    applyStimulus(0, 0, 1, randLine(), 32'h800C, 0);
    applyStimulus(0, 0, 1, randLine(), 32'h900C, 1);
    checkOutput("w_pc0", 64'(pc0), 64'(32'h7000));
    checkOutput("w_stall", 64'(stall), 64'(1));
    applyStimulus(0, 0, 1, randLine(), 32'hA004, 1);
    checkOutput("w_pc0b", 64'(pc0), 64'(32'h7008));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("w_pc0c", 64'(pc0), 64'(32'h800C));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("w_pc0d", 64'(pc0), 64'(32'h900C));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("w_pc0e", 64'(pc0), 64'(32'hA004));
    checkOutput("w_pc1e", 64'(pc1), 64'(32'hA008));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("w_vldf", 64'(vld), 64'(2'b01));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("w_empty", 64'(empty), 64'(1));

    applyStimulus(0, 0, 1, randLine(), 32'hB000, 0);
    applyStimulus(0, 0, 1, randLine(), 32'hC000, 0);
    applyStimulus(0, 0, 1, randLine(), 32'hD000, 0);
    applyStimulus(0, 1, 1, randLine(), 32'hE000, 0);
    checkOutput("fl_vld", 64'(vld), 64'(0));
    checkOutput("fl_empty", 64'(empty), 64'(1));
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("fl_empty2", 64'(empty), 64'(1));

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, randLine(), 32'hF000 + 32'(i*16), 0);
    applyStimulus(0, 0, 1, randLine(), 32'hFF00, 0);
    checkOutput("ov_stall", 64'(stall), 64'(1));
    checkOutput("ov_pc0", 64'(pc0), 64'(32'hF000));
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("ov_last_pc0", 64'(pc0), 64'(32'hF030));
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("ov_empty", 64'(empty), 64'(1));

    applyStimulus(0, 0, 1, randLine(), 32'h1230, 0);
    applyStimulus(1, 0, 1, randLine(), 32'h1240, 1);
    checkOutput("rs_vld", 64'(vld), 64'(0));
    checkOutput("rs_empty", 64'(empty), 64'(1));
    checkOutput("rs_stall", 64'(stall), 64'(0));

    for (int i = 0; i < 3000; i++) begin
      r_rst   = ($urandom_range(0, 199) == 0);
      r_flush = ($urandom_range(0, 31) == 0);
      r_vld   = ($urandom_range(0, 2) != 0) && (!stall || $urandom_range(0, 7) == 0);
      applyStimulus(r_rst, r_flush, r_vld, randLine(), $urandom() & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
